hazard_unit: RTL and testbench

- Pipeline hazard controller in the ID stage. It sits directly upstream of the ID/EX register and the operand forwarding logic.
- Detects load-use hazards that forwarding cannot cover, and tracks an in-flight multi-cycle divide so HI/LO consumers and back-to-back divides stall.
- Applies taken-branch flushes from EX.
- Drives PC/IF-ID write enables and IF/ID and ID/EX flushes, and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_unit.sv | 107 ++++++++++
 tb/tb_hazard_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// hazard_unit: ID-stage load-use / divide-busy stall and branch-flush control.
// Revision: 1.0
// ============================================================================
module hazard_unit #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       IF_ID_RS,
  input  logic [4:0]       IF_ID_RT,
  input  logic             ID_UsesRT,
  input  logic             ID_IsDiv,
  input  logic             ID_IsHiLoRead,
  input  logic [4:0]       ID_EX_RT,
  input  logic             ID_EX_MemRead,
  input  logic             EX_BranchTaken,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             DivBusy,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [0:0] C_ST_RUN      = 1'b0;
  localparam logic [0:0] C_ST_DIV_BUSY = 1'b1;
  localparam logic [7:0] C_DIV_LOAD    = 8'(DIV_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [7:0]       div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic w_lu;
  logic w_dh;
  logic w_stall;

  always_comb begin
    w_lu = ID_EX_MemRead && (ID_EX_RT != 5'd0) &&
           ((ID_EX_RT == IF_ID_RS) || (ID_UsesRT && (ID_EX_RT == IF_ID_RT)));
    w_dh    = (state_q == C_ST_DIV_BUSY) && (ID_IsDiv || ID_IsHiLoRead);
    w_stall = (w_lu || w_dh) && !EX_BranchTaken;
  end

  // A taken branch wins over any stall: the stalled instruction is flushed anyway.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    if (EX_BranchTaken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (w_stall) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    case (state_q)
      C_ST_RUN: begin
        if (ID_IsDiv && !w_stall && !EX_BranchTaken) begin
          state_d   = C_ST_DIV_BUSY;
          div_cnt_d = C_DIV_LOAD;
        end
      end
      default: begin
        // The divide is already past ID, so branches do not cut it short.
        if (div_cnt_q == 8'd0) begin
          state_d = C_ST_RUN;
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= C_ST_RUN;
      div_cnt_q   <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign DivBusy    = (state_q == C_ST_DIV_BUSY);
  assign StallCount = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_unit: directed + randomized checks against a cycle-level model.
// Revision: 1.0
// ============================================================================
module tb_hazard_unit;
  localparam int DIV_CYCLES = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [4:0]       IF_ID_RS, IF_ID_RT, ID_EX_RT;
  logic             ID_UsesRT, ID_IsDiv, ID_IsHiLoRead, ID_EX_MemRead, EX_BranchTaken;
  logic             PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, DivBusy;
  logic [CNT_W-1:0] StallCount;

  hazard_unit #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_ID_RS(IF_ID_RS), .IF_ID_RT(IF_ID_RT), .ID_UsesRT(ID_UsesRT),
    .ID_IsDiv(ID_IsDiv), .ID_IsHiLoRead(ID_IsHiLoRead),
    .ID_EX_RT(ID_EX_RT), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_BranchTaken(EX_BranchTaken),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .DivBusy(DivBusy), .StallCount(StallCount)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: busy cycles still owed by the divider, and a plain stall tally.
  int m_busy_left = 0;
  int m_stalls    = 0;

  function automatic bit model_stall();
    bit lu, dh;
    lu = ID_EX_MemRead && (ID_EX_RT != 0) &&
         ((ID_EX_RT == IF_ID_RS) || (ID_UsesRT && (ID_EX_RT == IF_ID_RT)));
    dh = (m_busy_left > 0) && (ID_IsDiv || ID_IsHiLoRead);
    return (lu || dh) && !EX_BranchTaken;
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_busy_left = 0;
      m_stalls    = 0;
    end else begin
      bit st;
      st = model_stall();
      if (st && m_stalls < CNT_MAX) m_stalls = m_stalls + 1;
      if (m_busy_left > 0) m_busy_left = m_busy_left - 1;
      else if (ID_IsDiv && !st && !EX_BranchTaken) m_busy_left = DIV_CYCLES;
    end
  end

  always @(negedge CLK) begin
    if (!RESET) begin
      bit st;
      logic [3:0] exp_ctl, act_ctl;
      st = model_stall();
      if (EX_BranchTaken) exp_ctl = 4'b1111;
      else if (st)        exp_ctl = 4'b0001;
      else                exp_ctl = 4'b1100;
      act_ctl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush};
      n_cmp++;
      if (act_ctl !== exp_ctl || DivBusy !== (m_busy_left > 0) ||
          StallCount !== CNT_W'(m_stalls)) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t: ctl=%b busy=%b cnt=%0d, expected ctl=%b busy=%b cnt=%0d",
                 $time, act_ctl, DivBusy, StallCount, exp_ctl, (m_busy_left > 0), m_stalls);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    IF_ID_RS = 5'd1; IF_ID_RT = 5'd2; ID_UsesRT = 1'b0; ID_IsDiv = 1'b0;
    ID_IsHiLoRead = 1'b0; ID_EX_RT = 5'd0; ID_EX_MemRead = 1'b0; EX_BranchTaken = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen;
    RESET = 1'b1;
    idle();
    #12;
    RESET = 1'b0;
    @(negedge CLK); #1;
    chk("reset_pcw", PC_Write, 1);
    chk("reset_ifw", IF_ID_Write, 1);
    chk("reset_flush", {IF_ID_Flush, ID_EX_Flush}, 0);
    chk("reset_busy", DivBusy, 0);
    chk("reset_cnt", StallCount, 0);

    // Load-use hit on rs
    next_cyc();
    ID_EX_MemRead = 1'b1; ID_EX_RT = 5'd8; IF_ID_RS = 5'd8;
    @(negedge CLK); #1;
    chk("lu_hit_ctl", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, 4'b0001);
    next_cyc();
    idle();
    chk("lu_hit_cnt", StallCount, 1);
    @(negedge CLK); #1;
    chk("lu_one_cycle", PC_Write, 1);

    // Rejections: rt match without use, and r0
    next_cyc();
    ID_EX_MemRead = 1'b1; ID_EX_RT = 5'd8; IF_ID_RT = 5'd8; ID_UsesRT = 1'b0;
    @(negedge CLK); #1;
    chk("lu_rt_unused", PC_Write, 1);
    next_cyc();
    ID_EX_RT = 5'd0; IF_ID_RS = 5'd0;
    @(negedge CLK); #1;
    chk("lu_r0", PC_Write, 1);

    // Divide then mfhi held in ID
    next_cyc();
    idle();
    ID_IsDiv = 1'b1;
    next_cyc();
    ID_IsDiv = 1'b0; ID_IsHiLoRead = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK); #1;
      chk($sformatf("div_busy_c%0d", i), DivBusy, (i <= 4) ? 1 : 0);
      chk($sformatf("mfhi_pcw_c%0d", i), PC_Write, (i <= 4) ? 0 : 1);
      if (i < 5) next_cyc();
    end
    chk("div_stall_cnt", StallCount, 5);
    next_cyc();
    idle();

    // Branch overrides load-use and an issuing divide
    EX_BranchTaken = 1'b1; ID_EX_MemRead = 1'b1; ID_EX_RT = 5'd8; IF_ID_RS = 5'd8; ID_IsDiv = 1'b1;
    @(negedge CLK); #1;
    chk("br_ctl", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, 4'b1111);
    next_cyc();
    idle();
    chk("br_no_div", DivBusy, 0);
    chk("br_cnt", StallCount, 5);

    // Back-to-back divides
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      ID_IsDiv = (i <= 5);
      @(negedge CLK); #1;
      if (DivBusy) busy_seen++;
      next_cyc();
    end
    idle();
    chk("b2b_busy_total", busy_seen, 2 * DIV_CYCLES);
    chk("b2b_cnt", StallCount, 9);

    // Saturation
    ID_EX_MemRead = 1'b1; ID_EX_RT = 5'd3; IF_ID_RS = 5'd3;
    repeat (20) next_cyc();
    idle();
    chk("sat_cnt", StallCount, CNT_MAX);

    // Asynchronous reset mid-divide
    ID_IsDiv = 1'b1;
    next_cyc();
    ID_IsDiv = 1'b0;
    next_cyc();
    chk("pre_rst_busy", DivBusy, 1);
    #2 RESET = 1'b1;
    #1;
    chk("rst_async_busy", DivBusy, 0);
    chk("rst_async_cnt", StallCount, 0);
    ID_IsHiLoRead = 1'b1;
    RESET = 1'b0;
    @(negedge CLK); #1;
    chk("rst_release_pcw", PC_Write, 1);
    next_cyc();
    idle();

    // Randomized traffic, checked every cycle by the model comparator
    for (int i = 0; i < 400; i++) begin
      IF_ID_RS       = 5'($urandom_range(0, 3));
      IF_ID_RT       = 5'($urandom_range(0, 3));
      ID_EX_RT       = 5'($urandom_range(0, 3));
      ID_UsesRT      = 1'($urandom_range(0, 1));
      ID_EX_MemRead  = 1'($urandom_range(0, 1));
      ID_IsDiv       = ($urandom_range(0, 5) == 0);
      ID_IsHiLoRead  = ($urandom_range(0, 3) == 0);
      EX_BranchTaken = ($urandom_range(0, 7) == 0);
      next_cyc();
    end
    idle();
    @(negedge CLK); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
